// File: rtl/con_pkg.sv
// Shared definitions for the console area-dispatch handshake: responder FSM
// state encodings, frame header byte, area bounds, and frame-length helper.
package con_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CHK     = 4'd1,
        ST_HDR0    = 4'd2,
        ST_HDR1    = 4'd3,
        ST_RD      = 4'd4,
        ST_WAIT    = 4'd5,
        ST_SEND_HI = 4'd6,
        ST_SEND_LO = 4'd7,
        ST_TRL     = 4'd8,
        ST_DONE    = 4'd9,
        ST_ERR     = 4'd10
    } con_state_t;

    localparam logic [7:0] CON_HDR     = 8'hA5;
    localparam int         CON_AREA_LO = 32'sd64;
    localparam int         CON_AREA_HI = 32'sd127;

    // Header byte + base byte + two bytes per word + checksum byte.
    function automatic int frame_len(input int words);
        return 32'sd3 + 32'sd2 * words;
    endfunction

endpackage

// File: rtl/con_tx_wdog.sv
// TX stall watchdog for the area responder. Counts consecutive cycles with a
// byte offered but not accepted and flags the cycle that reaches TMO_CYC.
// Only compiled when CON_RESP_TMO_EN is defined.
`ifdef CON_RESP_TMO_EN
module con_tx_wdog #(
    parameter int TMO_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_valid,
    input  logic tx_ready,
    output logic tmo
);

    localparam int CW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] LAST_C = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt_r;

    // Stall counter: advances while stalled, cleared by any handshake or idle link.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tx_valid && !tx_ready) begin
            if (cnt_r != LAST_C) begin
                cnt_r <= cnt_r + CW'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= '0;
        end
    end

    // Timeout flags the TMO_CYC-th consecutive stalled cycle.
    assign tmo = tx_valid & ~tx_ready & (cnt_r == LAST_C);

endmodule
`endif

// File: rtl/con_area_rd_resp.sv
// Area-2 responder: on a start pulse, range-checks the base address, reads
// WORDS words from area RAM and streams a framed byte response
// (A5, base[7:0], hi/lo per word, checksum) on a valid/ready link.
// Optional TX stall watchdog enabled by defining CON_RESP_TMO_EN.
module con_area_rd_resp
    import con_pkg::*;
#(
    parameter int AREA_LO = CON_AREA_LO,
    parameter int AREA_HI = CON_AREA_HI,
    parameter int WORDS   = 2,
    parameter int RAM_LAT = 2
`ifdef CON_RESP_TMO_EN
    ,
    parameter int TMO_CYC = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [11:0] im_base_addr,
    output logic        o_done,
    output logic        o_error,
    output logic        o_busy,
    output logic        o_ram_rd,
    output logic [11:0] om_ram_addr,
    input  logic [15:0] im_ram_data,
    output logic [7:0]  om_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
);

    localparam logic [3:0]  LAST_W = 4'(WORDS - 1);
    localparam logic [2:0]  LAT_C  = 3'(RAM_LAT);
    localparam logic [12:0] LO_C   = 13'(AREA_LO);
    localparam logic [12:0] HI_C   = 13'(AREA_HI);
    localparam logic [12:0] SPAN_C = 13'(WORDS - 1);

    con_state_t  state_r, state_nxt_s;
    logic [11:0] base_r, base_nxt_s;
    logic [3:0]  wcnt_r, wcnt_nxt_s;
    logic [2:0]  lat_r, lat_nxt_s;
    logic [7:0]  lo_r, lo_nxt_s;
    logic [7:0]  cksum_r, cksum_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic        error_r, error_nxt_s;
    logic        ram_rd_r, ram_rd_nxt_s;
    logic [11:0] ram_addr_r, ram_addr_nxt_s;
    logic [7:0]  tx_data_r, tx_data_nxt_s;
    logic        tx_valid_r, tx_valid_nxt_s;

    logic        hs_s;
    logic        legal_s;
    logic [7:0]  cksum_sum_s;
    logic        tmo_s;

`ifdef CON_RESP_TMO_EN
    con_tx_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid_r),
        .tx_ready (i_tx_ready),
        .tmo      (tmo_s)
    );
`else
    assign tmo_s = 1'b0;
`endif

    assign hs_s        = tx_valid_r & i_tx_ready;
    assign cksum_sum_s = cksum_r + tx_data_r;
    // 13-bit arithmetic so a base near the top of the 12-bit space cannot wrap.
    assign legal_s     = ({1'b0, base_r} >= LO_C) && (({1'b0, base_r} + SPAN_C) <= HI_C);

    // Next-state and next-output logic for the response sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        base_nxt_s     = base_r;
        wcnt_nxt_s     = wcnt_r;
        lat_nxt_s      = lat_r;
        lo_nxt_s       = lo_r;
        cksum_nxt_s    = hs_s ? cksum_sum_s : cksum_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        error_nxt_s    = 1'b0;
        ram_rd_nxt_s   = 1'b0;
        ram_addr_nxt_s = ram_addr_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = ST_CHK;
                    base_nxt_s  = im_base_addr;
                    busy_nxt_s  = 1'b1;
                    cksum_nxt_s = 8'd0;
                    wcnt_nxt_s  = 4'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (legal_s) begin
                    state_nxt_s    = ST_HDR0;
                    tx_data_nxt_s  = CON_HDR;
                    tx_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ERR;
                    error_nxt_s = 1'b1;
                end
            end
            ST_HDR0: begin
                if (hs_s) begin
                    state_nxt_s   = ST_HDR1;
                    tx_data_nxt_s = base_r[7:0];
                end else begin
                    state_nxt_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (hs_s) begin
                    state_nxt_s    = ST_RD;
                    tx_valid_nxt_s = 1'b0;
                    ram_rd_nxt_s   = 1'b1;
                    ram_addr_nxt_s = base_r + {8'd0, wcnt_r};
                end else begin
                    state_nxt_s = ST_HDR1;
                end
            end
            ST_RD: begin
                state_nxt_s = ST_WAIT;
                lat_nxt_s   = 3'd1;
            end
            ST_WAIT: begin
                if (lat_r == LAT_C) begin
                    state_nxt_s    = ST_SEND_HI;
                    tx_data_nxt_s  = im_ram_data[15:8];
                    lo_nxt_s       = im_ram_data[7:0];
                    tx_valid_nxt_s = 1'b1;
                end else begin
                    lat_nxt_s = lat_r + 3'd1;
                end
            end
            ST_SEND_HI: begin
                if (hs_s) begin
                    state_nxt_s   = ST_SEND_LO;
                    tx_data_nxt_s = lo_r;
                end else begin
                    state_nxt_s = ST_SEND_HI;
                end
            end
            ST_SEND_LO: begin
                if (hs_s) begin
                    if (wcnt_r == LAST_W) begin
                        state_nxt_s   = ST_TRL;
                        tx_data_nxt_s = cksum_sum_s;
                    end else begin
                        state_nxt_s    = ST_RD;
                        tx_valid_nxt_s = 1'b0;
                        wcnt_nxt_s     = wcnt_r + 4'd1;
                        ram_rd_nxt_s   = 1'b1;
                        ram_addr_nxt_s = base_r + {8'd0, wcnt_r + 4'd1};
                    end
                end else begin
                    state_nxt_s = ST_SEND_LO;
                end
            end
            ST_TRL: begin
                if (hs_s) begin
                    state_nxt_s    = ST_DONE;
                    tx_valid_nxt_s = 1'b0;
                    done_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_TRL;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
            ST_ERR: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                busy_nxt_s     = 1'b0;
                tx_valid_nxt_s = 1'b0;
            end
        endcase

        // A stalled link past the watchdog limit abandons the frame.
        if (tmo_s) begin
            state_nxt_s    = ST_ERR;
            tx_valid_nxt_s = 1'b0;
            error_nxt_s    = 1'b1;
            done_nxt_s     = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            base_r     <= 12'd0;
            wcnt_r     <= 4'd0;
            lat_r      <= 3'd0;
            lo_r       <= 8'd0;
            cksum_r    <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            ram_rd_r   <= 1'b0;
            ram_addr_r <= 12'd0;
            tx_data_r  <= 8'd0;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            base_r     <= base_nxt_s;
            wcnt_r     <= wcnt_nxt_s;
            lat_r      <= lat_nxt_s;
            lo_r       <= lo_nxt_s;
            cksum_r    <= cksum_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            error_r    <= error_nxt_s;
            ram_rd_r   <= ram_rd_nxt_s;
            ram_addr_r <= ram_addr_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
        end
    end

    assign o_done      = done_r;
    assign o_error     = error_r;
    assign o_busy      = busy_r;
    assign o_ram_rd    = ram_rd_r;
    assign om_ram_addr = ram_addr_r;
    assign om_tx_data  = tx_data_r;
    assign o_tx_valid  = tx_valid_r;

endmodule

// File: tb/tb_con_area_rd_resp.sv
// Scoreboard bench for con_area_rd_resp: expected frame bytes and RAM
// addresses are queued when a request is issued and checked as the DUT emits them.
module tb_con_area_rd_resp;
    import con_pkg::*;

    localparam int WORDS = 2;
    localparam int STALL = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [11:0] im_base_addr = 12'd0;
    logic        o_done, o_error, o_busy, o_ram_rd, o_tx_valid;
    logic [11:0] om_ram_addr;
    logic [15:0] im_ram_data = 16'hDEAD;
    logic [7:0]  om_tx_data;
    logic        i_tx_ready = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] mem [0:4095];
    logic [7:0]  exp_q[$];
    logic [11:0] addr_q[$];

    int cyc = 0, st_cyc = 0, err_cyc = 0;
    int done_total = 0, err_total = 0, rd_total = 0, valid_total = 0, hs_total = 0;
    int hs_base = 0, ready_mode = 0, stall_cnt = 0;
    bit rd_d1 = 1'b0, rd_d2 = 1'b0, prev_stall = 1'b0;
    logic [11:0] addr_d1 = 12'd0, addr_d2 = 12'd0;
    logic [7:0]  prev_data = 8'd0;

    con_area_rd_resp dut (
        .clk(clk), .rst(rst), .i_start(i_start), .im_base_addr(im_base_addr),
        .o_done(o_done), .o_error(o_error), .o_busy(o_busy), .o_ram_rd(o_ram_rd),
        .om_ram_addr(om_ram_addr), .im_ram_data(im_ram_data), .om_tx_data(om_tx_data),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready)
    );

    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc = cyc + 1;

    // RAM model: data appears two cycles after the read strobe, junk otherwise.
    always @(negedge clk) begin
        im_ram_data = rd_d2 ? mem[addr_d2] : 16'hDEAD;
        rd_d2 = rd_d1;  addr_d2 = addr_d1;
        rd_d1 = o_ram_rd; addr_d1 = om_ram_addr;
    end

    // TX sink ready pattern.
    always begin
        @(posedge clk); #1;
        case (ready_mode)
            0: begin i_tx_ready = 1'b1; stall_cnt = 0; end
            1: begin i_tx_ready = ~i_tx_ready; stall_cnt = 0; end
            2: begin
                if ((hs_total - hs_base) == 3 && stall_cnt < STALL) begin
                    i_tx_ready = 1'b0;
                    stall_cnt = stall_cnt + 1;
                end else begin
                    i_tx_ready = 1'b1;
                end
            end
            default: begin i_tx_ready = 1'b0; stall_cnt = 0; end
        endcase
    end

    // Monitor: pulse counters, RAM address and TX byte scoreboards, hold stability.
    always @(negedge clk) begin
        logic [7:0]  eb;
        logic [11:0] ea;
        if (i_start) st_cyc = cyc;
        if (o_tx_valid === 1'b1) valid_total++;
        if (o_done === 1'b1) done_total++;
        if (o_error === 1'b1) begin err_total++; err_cyc = cyc; end
        if (o_done === 1'b1 || o_error === 1'b1) begin
            tests_run++;
            if ((o_done & o_error) !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_error_excl: done=%b error=%b, required not both", o_done, o_error);
            end
        end
        if (o_ram_rd === 1'b1 && !rst) begin
            rd_total++;
            tests_run++;
            if (addr_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ram_rd_unexpected: addr=%h, required no read", om_ram_addr);
            end else begin
                ea = addr_q.pop_front();
                if (om_ram_addr !== ea) begin
                    tests_failed++;
                    $display("FAIL ram_addr: got %h, required %h", om_ram_addr, ea);
                end
            end
        end
        if (prev_stall && !rst && o_error !== 1'b1) begin
            tests_run++;
            if (o_tx_valid !== 1'b1 || om_tx_data !== prev_data) begin
                tests_failed++;
                $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h",
                         o_tx_valid, om_tx_data, prev_data);
            end
        end
        if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1 && !rst) begin
            hs_total++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL tx_byte_unexpected: got %h, required no byte", om_tx_data);
            end else begin
                eb = exp_q.pop_front();
                if (om_tx_data !== eb) begin
                    tests_failed++;
                    $display("FAIL tx_byte: got %h, required %h", om_tx_data, eb);
                end
            end
        end
        prev_stall = (o_tx_valid === 1'b1) && (i_tx_ready === 1'b0) && !rst;
        prev_data  = om_tx_data;
    end

    task automatic push_frame(input logic [11:0] b);
        logic [7:0]  s;
        logic [15:0] w;
        logic [11:0] a;
        exp_q.push_back(CON_HDR);
        s = CON_HDR;
        exp_q.push_back(b[7:0]);
        s = s + b[7:0];
        for (int k = 0; k < WORDS; k++) begin
            a = b + 12'(k);
            w = mem[a];
            addr_q.push_back(a);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            s = s + w[15:8] + w[7:0];
        end
        exp_q.push_back(s);
    endtask

    task automatic run_frame(input logic [11:0] b, input int mode, input bit inj_en,
                             input logic [11:0] inj);
        int d0, e0, r0, v0, h0;
        bit rng_ok, tmo_exp, ended;
        rng_ok  = (b >= 12'd64) && (({1'b0, b} + 13'(WORDS - 1)) <= 13'd127);
        tmo_exp = 1'b0;
`ifdef CON_RESP_TMO_EN
        if (mode == 2) tmo_exp = 1'b1;
`endif
        ready_mode = mode;
        hs_base = hs_total;
        d0 = done_total; e0 = err_total; r0 = rd_total; v0 = valid_total; h0 = hs_total;
        if (rng_ok) push_frame(b);
        i_start = 1'b1; im_base_addr = b;
        @(posedge clk); #1;
        i_start = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_total != d0 || err_total != e0) begin ended = 1'b1; break; end
            if (inj_en && i == 4) begin
                i_start = 1'b1; im_base_addr = inj;
                tests_run++;
                if (o_busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL busy_mid_frame: got %b, required 1", o_busy);
                end
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (!ended) begin
            tests_failed++;
            $display("FAIL end_timeout: base=%h no done/error within budget", b);
        end
        tests_run++;
        if (rng_ok && !tmo_exp) begin
            if (done_total - d0 != 1 || err_total - e0 != 0) begin
                tests_failed++;
                $display("FAIL frame_pulses: done=%0d error=%0d, required 1/0",
                         done_total - d0, err_total - e0);
            end
            tests_run++;
            if (exp_q.size() != 0 || addr_q.size() != 0) begin
                tests_failed++;
                $display("FAIL frame_left: bytes=%0d addrs=%0d, required 0/0", exp_q.size(), addr_q.size());
            end
            tests_run++;
            if (hs_total - h0 != frame_len(WORDS) || rd_total - r0 != WORDS) begin
                tests_failed++;
                $display("FAIL frame_len: bytes=%0d reads=%0d, required %0d/%0d",
                         hs_total - h0, rd_total - r0, frame_len(WORDS), WORDS);
            end
        end else if (rng_ok) begin
            if (err_total - e0 != 1 || done_total - d0 != 0 || o_tx_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL tmo_abort: error=%0d done=%0d valid=%b, required 1/0/0",
                         err_total - e0, done_total - d0, o_tx_valid);
            end
            exp_q.delete();
            addr_q.delete();
        end else begin
            if (err_total - e0 != 1 || done_total - d0 != 0) begin
                tests_failed++;
                $display("FAIL range_pulses: error=%0d done=%0d, required 1/0",
                         err_total - e0, done_total - d0);
            end
            tests_run++;
            if (rd_total - r0 != 0 || valid_total - v0 != 0) begin
                tests_failed++;
                $display("FAIL range_quiet: reads=%0d valid_cycles=%0d, required 0/0",
                         rd_total - r0, valid_total - v0);
            end
            tests_run++;
            if (err_cyc - st_cyc != 2) begin
                tests_failed++;
                $display("FAIL range_latency: got %0d cycles, required 2", err_cyc - st_cyc);
            end
        end
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_end: got %b, required 0", o_busy);
        end
        ready_mode = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({o_done, o_error, o_busy, o_ram_rd, om_ram_addr, om_tx_data, o_tx_valid} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {o_done, o_error, o_busy, o_ram_rd, om_ram_addr, om_tx_data, o_tx_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();        run_frame(12'd64, 0, 1'b0, 12'd0); endtask
    task automatic test_range_error();  run_frame(12'd10, 0, 1'b0, 12'd0); endtask
    task automatic test_boundary();
        run_frame(12'd126, 0, 1'b0, 12'd0);
        run_frame(12'd127, 0, 1'b0, 12'd0);
    endtask
    task automatic test_ready_toggle(); run_frame(12'd64, 1, 1'b0, 12'd0); endtask
    task automatic test_stall();        run_frame(12'd64, 2, 1'b0, 12'd0); endtask
    task automatic test_busy_ignore();  run_frame(12'd64, 0, 1'b1, 12'd70); endtask

    task automatic test_reset_mid();
        int d0, e0;
        d0 = done_total; e0 = err_total;
        ready_mode = 3;
        i_start = 1'b1; im_base_addr = 12'd80;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int i = 0; i < 20 && o_tx_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (o_tx_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_valid: got %b, required 1", o_tx_valid);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({o_done, o_error, o_busy, o_ram_rd, om_ram_addr, om_tx_data, o_tx_valid} !== 25'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %h, required 0",
                     {o_done, o_error, o_busy, o_ram_rd, om_ram_addr, om_tx_data, o_tx_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (done_total != d0 || err_total != e0) begin
            tests_failed++;
            $display("FAIL midreset_pulses: done=%0d error=%0d, required 0/0",
                     done_total - d0, err_total - e0);
        end
        exp_q.delete();
        addr_q.delete();
        run_frame(12'd100, 0, 1'b0, 12'd0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            run_frame(12'($urandom_range(64, 126)), 1, 1'b0, 12'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 311 + 23130);
        mem[64] = 16'h1234;
        mem[65] = 16'hABCD;
        test_reset();
        test_basic();
        test_range_error();
        test_boundary();
        test_ready_toggle();
        test_stall();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
